// File: rtl/gate_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gate_seq_ctrl
//   Programmable gate-pulse sequencer. A period/high-time counter drives a
//   registered gate, either as a continuous stream (burst == 0) or as a
//   counted burst of periods. Configuration arrives over a valid/ready port.
//   While a run is in progress the word waits in shadow registers and is
//   copied to the active registers only on a period wrap, so a running gate
//   never glitches.
//
//   Optional feature: define GATE_DLY_EN to add the cfg_delay port, the
//   delay_act register and the DELAY state (start-delay before RUN).
//
// Ports
//   clk        in   1   system clock, all logic on posedge
//   rst_n      in   1   asynchronous active-low reset
//   cfg_valid  in   1   config word valid
//   cfg_ready  out  1   config port can accept (no word pending)
//   cfg_period in   CW  period-1
//   cfg_high   in   CW  gate-high cycles per period (must be <= cfg_period)
//   cfg_burst  in   BW  periods per run, 0 = continuous
//   cfg_delay  in   CW  start delay in cycles (GATE_DLY_EN only)
//   cfg_err    out  1   one-cycle pulse: config word rejected
//   start      in   1   begin a run
//   stop       in   1   graceful stop (finish the current period)
//   gate_out   out  1   registered gate output
//   busy       out  1   run in progress (state != IDLE)
//   pulse_cnt  out  BW  completed periods in current/last run
//   done       out  1   one-cycle pulse when a run ends
// ---------------------------------------------------------------------------
module gate_seq_ctrl #(
    parameter int unsigned     CW         = 28,
    parameter int unsigned     BW         = 16,
    parameter logic [CW-1:0]   DEF_PERIOD = CW'(23),
    parameter logic [CW-1:0]   DEF_HIGH   = CW'(20)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_high,
    input  logic [BW-1:0] cfg_burst,
`ifdef GATE_DLY_EN
    input  logic [CW-1:0] cfg_delay,
`endif
    output logic          cfg_err,
    input  logic          start,
    input  logic          stop,
    output logic          gate_out,
    output logic          busy,
    output logic [BW-1:0] pulse_cnt,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] per_act, per_n, high_act, high_n;
    logic [BW-1:0] burst_act, burst_n;
    logic [CW-1:0] per_shd, per_shd_n, high_shd, high_shd_n;
    logic [BW-1:0] burst_shd, burst_shd_n;
    logic          pending, pending_n;
    logic [BW-1:0] pulse_n;
    logic          gate_n, done_n, err_n;
`ifdef GATE_DLY_EN
    logic [CW-1:0] delay_act, delay_n, delay_shd, delay_shd_n;
`endif

    logic          counting, wrap, burst_hit;
    logic [BW:0]   pulse_p1;
    logic [BW-1:0] pulse_sat;

    assign counting  = (state == S_RUN) || (state == S_DRAIN);
    assign wrap      = counting && (cnt == per_act);
    // One extra bit so the burst compare is exact even at the top of the range.
    assign pulse_p1  = {1'b0, pulse_cnt} + {{BW{1'b0}}, 1'b1};
    assign pulse_sat = pulse_p1[BW] ? pulse_cnt : pulse_p1[BW-1:0];
    assign burst_hit = (burst_act != '0) && (pulse_p1 == {1'b0, burst_act});

    assign cfg_ready = !pending;
    assign busy      = (state != S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_n     = state;
        cnt_n       = cnt;
        pulse_n     = pulse_cnt;
        done_n      = 1'b0;
        err_n       = 1'b0;
        per_n       = per_act;
        high_n      = high_act;
        burst_n     = burst_act;
        per_shd_n   = per_shd;
        high_shd_n  = high_shd;
        burst_shd_n = burst_shd;
        pending_n   = pending;
`ifdef GATE_DLY_EN
        delay_n     = delay_act;
        delay_shd_n = delay_shd;
`endif

        case (state)
            S_IDLE: begin
                // start wins over a simultaneous stop.
                if (start) begin
                    cnt_n   = '0;
                    pulse_n = '0;
`ifdef GATE_DLY_EN
                    state_n = (delay_act != '0) ? S_DELAY : S_RUN;
`else
                    state_n = S_RUN;
`endif
                end
            end
`ifdef GATE_DLY_EN
            S_DELAY: begin
                if (stop) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    pulse_n = '0;
                    cnt_n   = '0;
                end else if (cnt == delay_act - CW'(1)) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            S_RUN, S_DRAIN: begin
                if (wrap) begin
                    cnt_n   = '0;
                    pulse_n = pulse_sat;
                    if ((state == S_DRAIN) || burst_hit) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else if (stop) begin
                        state_n = S_DRAIN;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (stop) state_n = S_DRAIN;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A held word lands on the wrap edge and governs the next period; the
        // IDLE clause drains a word left behind by a run aborted from DELAY.
        if (pending && (wrap || (state == S_IDLE))) begin
            per_n     = per_shd;
            high_n    = high_shd;
            burst_n   = burst_shd;
`ifdef GATE_DLY_EN
            delay_n   = delay_shd;
`endif
            pending_n = 1'b0;
        end

        // Transfer only when no word is pending, so this never collides with
        // the shadow copy above.
        if (cfg_valid && !pending) begin
            if (cfg_high > cfg_period) begin
                err_n = 1'b1;
            end else if (state == S_IDLE) begin
                per_n   = cfg_period;
                high_n  = cfg_high;
                burst_n = cfg_burst;
`ifdef GATE_DLY_EN
                delay_n = cfg_delay;
`endif
            end else begin
                per_shd_n   = cfg_period;
                high_shd_n  = cfg_high;
                burst_shd_n = cfg_burst;
`ifdef GATE_DLY_EN
                delay_shd_n = cfg_delay;
`endif
                pending_n   = 1'b1;
            end
        end

        // Gate is computed from next-state values so the register output is
        // aligned with the counter it describes.
        gate_n = ((state_n == S_RUN) || (state_n == S_DRAIN)) && (cnt_n < high_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            per_act   <= DEF_PERIOD;
            high_act  <= DEF_HIGH;
            burst_act <= '0;
            per_shd   <= '0;
            high_shd  <= '0;
            burst_shd <= '0;
            pending   <= 1'b0;
            pulse_cnt <= '0;
            gate_out  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef GATE_DLY_EN
            delay_act <= '0;
            delay_shd <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state     <= state_n;
            cnt       <= cnt_n;
            per_act   <= per_n;
            high_act  <= high_n;
            burst_act <= burst_n;
            per_shd   <= per_shd_n;
            high_shd  <= high_shd_n;
            burst_shd <= burst_shd_n;
            pending   <= pending_n;
            pulse_cnt <= pulse_n;
            gate_out  <= gate_n;
            done      <= done_n;
            cfg_err   <= err_n;
`ifdef GATE_DLY_EN
            delay_act <= delay_n;
            delay_shd <= delay_shd_n;
`endif
        end
    end

endmodule
